// File: rtl/byte2pixel_rgb888_2lane.sv
// byte2pixel_rgb888_2lane
// Regroups a 2-lane (16-bit per clock) long-packet payload into 24-bit RGB888
// pixels with line_start/line_end markers. Non-RGB888 packets are consumed
// and discarded. Everything runs in the byte clock domain.
module byte2pixel_rgb888_2lane #(
  parameter logic [5:0] DT_RGB888 = 6'h24,
  parameter int         WC_W      = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            pkt_start,
  input  logic [5:0]      dt,
  input  logic [WC_W-1:0] wc,
  input  logic            payload_en,
  input  logic [15:0]     payload,
  output logic [23:0]     pixel_data,
  output logic            pixel_valid,
  output logic            line_start,
  output logic            line_end,
  output logic            err_wc,
  output logic            err_trunc
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DROP   = 2'd2
  } state_t;

  localparam logic [WC_W-1:0] WC_TWO   = WC_W'(2);
  localparam logic [WC_W-1:0] WC_THREE = WC_W'(3);

  state_t          state_q, state_d;
  logic [WC_W-1:0] remaining_q, remaining_d;
  logic [1:0]      phase_q, phase_d;
  logic [15:0]     hold_q, hold_d;
  logic            first_q, first_d;
  logic [23:0]     pixel_data_q, pixel_data_d;
  logic            pixel_valid_q, pixel_valid_d;
  logic            line_start_q, line_start_d;
  logic            line_end_q, line_end_d;
  logic            err_wc_q, err_wc_d;
  logic            err_trunc_q, err_trunc_d;

  logic            wc_ok;
  logic [WC_W-1:0] rem_after;
  logic            emit;

  // A valid RGB888 line must carry a whole, non-zero number of pixels.
  assign wc_ok = (wc != '0) && ((wc % WC_THREE) == '0);

  // A beat consumes two bytes, or only lane0 when one byte is left.
  assign rem_after = (remaining_q >= WC_TWO) ? (remaining_q - WC_TWO) : '0;

  // Next-state: header handling has priority over payload; gearbox in ACTIVE.
  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    phase_d       = phase_q;
    hold_d        = hold_q;
    first_d       = first_q;
    pixel_data_d  = pixel_data_q;
    pixel_valid_d = 1'b0;
    line_start_d  = 1'b0;
    line_end_d    = 1'b0;
    err_wc_d      = 1'b0;
    err_trunc_d   = 1'b0;
    emit          = 1'b0;

    if (pkt_start) begin
      remaining_d = wc;
      phase_d     = 2'd0;
      hold_d      = '0;
      first_d     = 1'b1;
      err_trunc_d = (state_q != S_IDLE) && (remaining_q != '0);
      if (dt == DT_RGB888) begin
        err_wc_d = !wc_ok;
        state_d  = wc_ok ? S_ACTIVE : ((wc == '0) ? S_IDLE : S_DROP);
      end else begin
        state_d  = (wc == '0) ? S_IDLE : S_DROP;
      end
    end else if (payload_en && (state_q != S_IDLE)) begin
      remaining_d = rem_after;
      if (rem_after == '0) begin
        state_d = S_IDLE;
      end
      if (state_q == S_ACTIVE) begin
        // Stream order per pixel is B,G,R; the hold register keeps the
        // bytes of a pixel that straddles two beats.
        case (phase_q)
          2'd0: begin
            hold_d  = payload;
            phase_d = 2'd1;
          end
          2'd1: begin
            pixel_data_d = {payload[7:0], hold_q[15:8], hold_q[7:0]};
            hold_d       = {8'h00, payload[15:8]};
            phase_d      = 2'd2;
            emit         = 1'b1;
          end
          default: begin
            pixel_data_d = {payload[15:8], payload[7:0], hold_q[7:0]};
            phase_d      = 2'd0;
            emit         = 1'b1;
          end
        endcase
        if (emit) begin
          pixel_valid_d = 1'b1;
          line_start_d  = first_q;
          first_d       = 1'b0;
          line_end_d    = (rem_after == '0);
        end
      end
    end
  end

  // State and registered outputs; asynchronous reset clears everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      remaining_q   <= '0;
      phase_q       <= 2'd0;
      hold_q        <= '0;
      first_q       <= 1'b0;
      pixel_data_q  <= '0;
      pixel_valid_q <= 1'b0;
      line_start_q  <= 1'b0;
      line_end_q    <= 1'b0;
      err_wc_q      <= 1'b0;
      err_trunc_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      phase_q       <= phase_d;
      hold_q        <= hold_d;
      first_q       <= first_d;
      pixel_data_q  <= pixel_data_d;
      pixel_valid_q <= pixel_valid_d;
      line_start_q  <= line_start_d;
      line_end_q    <= line_end_d;
      err_wc_q      <= err_wc_d;
      err_trunc_q   <= err_trunc_d;
    end
  end

  assign pixel_data  = pixel_data_q;
  assign pixel_valid = pixel_valid_q;
  assign line_start  = line_start_q;
  assign line_end    = line_end_q;
  assign err_wc      = err_wc_q;
  assign err_trunc   = err_trunc_q;

endmodule

// File: tb/tb_byte2pixel_rgb888_2lane.sv
// Self-checking bench for byte2pixel_rgb888_2lane: directed packets followed by
// randomized packets, checked against a byte-stream reference model.
module tb_byte2pixel_rgb888_2lane;

  localparam logic [5:0] DT_RGB = 6'h24;
  localparam logic [5:0] DT_OTHER = 6'h2B;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pkt_start = 1'b0;
  logic [5:0]  dt = '0;
  logic [15:0] wc = '0;
  logic        payload_en = 1'b0;
  logic [15:0] payload = '0;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic        line_start;
  logic        line_end;
  logic        err_wc;
  logic        err_trunc;

  int checks = 0;
  int errors = 0;
  int model_rem = 0;         // bytes still owed by the packet in flight
  logic [23:0] last_pix = '0;

  always #5 clk = ~clk;

  byte2pixel_rgb888_2lane #(
    .DT_RGB888(DT_RGB),
    .WC_W(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .pkt_start(pkt_start),
    .dt(dt),
    .wc(wc),
    .payload_en(payload_en),
    .payload(payload),
    .pixel_data(pixel_data),
    .pixel_valid(pixel_valid),
    .line_start(line_start),
    .line_end(line_end),
    .err_wc(err_wc),
    .err_trunc(err_trunc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Outputs expected when no pixel completes and no error is flagged.
  task automatic chk_quiet(input string tag);
    chk({tag, ".pixel_valid"}, 32'(pixel_valid), 32'd0);
    chk({tag, ".pixel_data_hold"}, 32'(pixel_data), 32'(last_pix));
    chk({tag, ".err_wc"}, 32'(err_wc), 32'd0);
    chk({tag, ".err_trunc"}, 32'(err_trunc), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".pixel_data"}, 32'(pixel_data), 32'd0);
    chk({tag, ".pixel_valid"}, 32'(pixel_valid), 32'd0);
    chk({tag, ".line_start"}, 32'(line_start), 32'd0);
    chk({tag, ".line_end"}, 32'(line_end), 32'd0);
    chk({tag, ".err_wc"}, 32'(err_wc), 32'd0);
    chk({tag, ".err_trunc"}, 32'(err_trunc), 32'd0);
  endtask

  // Send one packet header and up to max_beats payload beats.
  // seq=1 makes byte k of the payload equal k+1; otherwise bytes are random.
  task automatic run_pkt(input logic [5:0] d, input int w, input int max_beats,
                         input bit seq, input int min_gap, input int max_gap);
    logic [7:0]  bytes[$];
    logic [7:0]  b0, b1;
    logic [23:0] px;
    int          consumed;
    int          npix;
    int          beat;
    int          gap;
    bit          active;
    consumed = 0;
    npix = 0;
    beat = 0;
    active = (d == DT_RGB) && (w != 0) && (w % 3 == 0);

    // Header with a coincident beat that must be thrown away.
    pkt_start = 1'b1;
    dt = d;
    wc = 16'(w);
    payload_en = 1'b1;
    payload = 16'($urandom);
    tick;
    pkt_start = 1'b0;
    payload_en = 1'b0;
    chk("hdr.err_wc", 32'(err_wc), 32'((d == DT_RGB) && ((w == 0) || (w % 3 != 0))));
    chk("hdr.err_trunc", 32'(err_trunc), 32'(model_rem != 0));
    chk("hdr.pixel_valid", 32'(pixel_valid), 32'd0);
    model_rem = w;

    while ((consumed < w) && (beat < max_beats)) begin
      gap = $urandom_range(max_gap, min_gap);
      repeat (gap) begin
        tick;
        chk_quiet("gap");
      end
      b0 = seq ? 8'(consumed + 1) : 8'($urandom);
      b1 = seq ? 8'(consumed + 2) : 8'($urandom);
      bytes.push_back(b0);
      if (w - consumed >= 2) begin
        bytes.push_back(b1);
        consumed = consumed + 2;
      end else begin
        b1 = 8'($urandom);       // unused lane1 carries junk
        consumed = w;
      end
      payload_en = 1'b1;
      payload = {b1, b0};
      tick;
      payload_en = 1'b0;
      beat++;
      model_rem = w - consumed;
      if (active && (consumed / 3 > npix)) begin
        px = {bytes[3*npix+2], bytes[3*npix+1], bytes[3*npix]};
        chk("pix.pixel_valid", 32'(pixel_valid), 32'd1);
        chk("pix.pixel_data", 32'(pixel_data), 32'(px));
        chk("pix.line_start", 32'(line_start), 32'(npix == 0));
        chk("pix.line_end", 32'(line_end), 32'(consumed == w));
        chk("pix.err_wc", 32'(err_wc), 32'd0);
        chk("pix.err_trunc", 32'(err_trunc), 32'd0);
        last_pix = px;
        npix++;
      end else begin
        chk_quiet("beat");
      end
    end
    $display("pkt dt=%02h wc=%0d beats=%0d pixels=%0d remaining=%0d",
             d, w, beat, npix, model_rem);
  endtask

  // A beat with no packet in progress must have no effect.
  task automatic idle_beat;
    payload_en = 1'b1;
    payload = 16'($urandom);
    tick;
    payload_en = 1'b0;
    chk_quiet("idle_beat");
    $display("idle beat payload=%04h", payload);
  endtask

  initial begin
    int d_sel;
    int w;
    int mb;

    // Reset state
    repeat (3) tick;
    chk_all_zero("reset");
    reset_n = 1'b1;
    tick;
    chk_all_zero("post_reset");

    // 1: two pixels
    run_pkt(DT_RGB, 6, 100, 1'b1, 0, 0);
    // 2: odd wc, final lane0-only beat, then IDLE ignores payload
    run_pkt(DT_RGB, 9, 100, 1'b1, 0, 0);
    idle_beat();
    // 3: single pixel with gaps of 4 idle clocks
    run_pkt(DT_RGB, 3, 100, 1'b1, 4, 4);
    // 4: foreign data type dropped, then bad wc dropped with error
    run_pkt(DT_OTHER, 12, 100, 1'b0, 0, 0);
    run_pkt(DT_RGB, 10, 100, 1'b0, 0, 0);
    idle_beat();
    // 5: truncated packet followed by a good one
    run_pkt(DT_RGB, 12, 2, 1'b1, 0, 0);
    run_pkt(DT_RGB, 12, 100, 1'b0, 0, 1);
    // zero-length packets
    run_pkt(DT_OTHER, 0, 100, 1'b0, 0, 0);
    run_pkt(DT_RGB, 0, 100, 1'b0, 0, 0);

    // 6: asynchronous reset mid-packet, right after a pixel came out
    run_pkt(DT_RGB, 12, 2, 1'b0, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    $display("async reset asserted mid-packet");
    model_rem = 0;
    last_pix = '0;
    tick;
    tick;
    reset_n = 1'b1;
    tick;
    chk_all_zero("after_reset");
    run_pkt(DT_RGB, 6, 100, 1'b0, 0, 0);

    // Randomized packets, including aborts and odd lengths
    for (int n = 0; n < 40; n++) begin
      d_sel = $urandom_range(3, 0);
      if ($urandom_range(4, 0) == 0) begin
        w = $urandom_range(20, 0);
      end else begin
        w = 3 * $urandom_range(10, 1);
      end
      mb = ($urandom_range(3, 0) == 0) ? $urandom_range(4, 1) : 1000;
      run_pkt((d_sel == 0) ? DT_OTHER : DT_RGB, w, mb, 1'b0, 0, 2);
      if ($urandom_range(3, 0) == 0) begin
        idle_beat();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
